// File: rtl/elevator_ctrl_n_if.sv
// Request/status bundle between the keypad front end and the elevator controller.
interface elevator_ctrl_n_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic [FLOOR_W-1:0] cur_floor;
    logic               dir_up;
    logic               moving;
    logic               door_open;
    logic               arrive;
    logic [FLOORS-1:0]  pending;
    logic [2:0]         state;

    modport master (
        output req_valid, req_floor,
        input  cur_floor, dir_up, moving, door_open, arrive, pending, state
    );

    modport slave (
        input  req_valid, req_floor,
        output cur_floor, dir_up, moving, door_open, arrive, pending, state
    );
endinterface

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller with internal travel and door timers.
// Optional emergency stop (HALT state, estop port) enabled by ELEVATOR_ESTOP_EN.
module elevator_ctrl_n #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 16,
    parameter int DOOR_CYC   = 32,
    parameter int TMR_W      = 8
) (
    input logic               clk,
    input logic               reset,
`ifdef ELEVATOR_ESTOP_EN
    input logic               estop,
`endif
    elevator_ctrl_n_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECIDE = 3'd1,
        MOVE   = 3'd2,
        DOOR   = 3'd3
`ifdef ELEVATOR_ESTOP_EN
        , HALT = 3'd4
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] curFloor_q, curFloor_d;
    logic               dirUp_q, dirUp_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               moving_q, moving_d;
    logic               doorOpen_q, doorOpen_d;
    logic               arrive_q, arrive_d;
`ifdef ELEVATOR_ESTOP_EN
    state_t             savedState_q, savedState_d;
    logic [TMR_W-1:0]   savedTimer_q, savedTimer_d;
`endif

    logic [FLOORS-1:0]  setMask, clrMask;
    logic               reqInRange, sameFloorDoor;
    logic               anyAbove, anyBelow, ahead, behind;

    always_comb begin
        reqInRange    = bus.req_valid && (int'(bus.req_floor) < FLOORS);
        sameFloorDoor = bus.req_valid && (state_q == DOOR) && (bus.req_floor == curFloor_q);
        setMask       = '0;
        if (reqInRange && !sameFloorDoor) setMask[bus.req_floor] = 1'b1;

        anyAbove = 1'b0;
        anyBelow = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (i > int'(curFloor_q))) anyAbove = 1'b1;
            if (pending_q[i] && (i < int'(curFloor_q))) anyBelow = 1'b1;
        end
        ahead  = dirUp_q ? anyAbove : anyBelow;
        behind = dirUp_q ? anyBelow : anyAbove;
    end

    always_comb begin
        state_d    = state_q;
        curFloor_d = curFloor_q;
        dirUp_d    = dirUp_q;
        timer_d    = timer_q;
        clrMask    = '0;
`ifdef ELEVATOR_ESTOP_EN
        savedState_d = savedState_q;
        savedTimer_d = savedTimer_q;
`endif

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (|pending_q) state_d = DECIDE;
            end
            DECIDE: begin
                timer_d = '0;
                if (pending_q[curFloor_q]) begin
                    clrMask[curFloor_q] = 1'b1;
                    state_d             = DOOR;
                end else if (ahead) begin
                    state_d = MOVE;
                end else if (behind) begin
                    dirUp_d = ~dirUp_q;
                    state_d = MOVE;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (timer_q == TMR_W'(TRAVEL_CYC - 1)) begin
                    curFloor_d = dirUp_q ? curFloor_q + FLOOR_W'(1) : curFloor_q - FLOOR_W'(1);
                    timer_d    = '0;
                    state_d    = DECIDE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DOOR: begin
                if (sameFloorDoor) begin
                    timer_d = '0;
                end else if (timer_q == TMR_W'(DOOR_CYC - 1)) begin
                    timer_d = '0;
                    state_d = (|pending_q) ? DECIDE : IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`ifdef ELEVATOR_ESTOP_EN
            HALT: begin
                if (!estop) begin
                    state_d = savedState_q;
                    timer_d = savedTimer_q;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop freezes everything except request latching.
        if (estop && (state_q != HALT)) begin
            state_d      = HALT;
            timer_d      = timer_q;
            curFloor_d   = curFloor_q;
            dirUp_d      = dirUp_q;
            clrMask      = '0;
            savedState_d = state_q;
            savedTimer_d = timer_q;
        end
`endif

        pending_d  = (pending_q & ~clrMask) | setMask;
        moving_d   = (state_d == MOVE);
        doorOpen_d = (state_d == DOOR);
        arrive_d   = (state_q == MOVE) && (state_d == DECIDE);
`ifdef ELEVATOR_ESTOP_EN
        if (state_d == HALT) doorOpen_d = doorOpen_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            curFloor_q <= '0;
            dirUp_q    <= 1'b1;
            pending_q  <= '0;
            timer_q    <= '0;
            moving_q   <= 1'b0;
            doorOpen_q <= 1'b0;
            arrive_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            curFloor_q <= curFloor_d;
            dirUp_q    <= dirUp_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            moving_q   <= moving_d;
            doorOpen_q <= doorOpen_d;
            arrive_q   <= arrive_d;
        end
    end

`ifdef ELEVATOR_ESTOP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            savedState_q <= IDLE;
            savedTimer_q <= '0;
        end else begin
            savedState_q <= savedState_d;
            savedTimer_q <= savedTimer_d;
        end
    end
`endif

    assign bus.cur_floor = curFloor_q;
    assign bus.dir_up    = dirUp_q;
    assign bus.moving    = moving_q;
    assign bus.door_open = doorOpen_q;
    assign bus.arrive    = arrive_q;
    assign bus.pending   = pending_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed self-checking bench for elevator_ctrl_n (FLOORS=6, TRAVEL_CYC=4, DOOR_CYC=6).
module tb_elevator_ctrl_n;
    localparam int FLOORS = 6;
    localparam int FLOOR_W = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECIDE = 3'd1;
    localparam logic [2:0] S_MOVE   = 3'd2;
    localparam logic [2:0] S_DOOR   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic clk;
    logic reset;
    logic estop;
    int   passCount;
    int   checkCount;

    elevator_ctrl_n_if #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) bus ();

    elevator_ctrl_n #(
        .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .TRAVEL_CYC(4), .DOOR_CYC(6), .TMR_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef ELEVATOR_ESTOP_EN
        .estop(estop),
`endif
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [FLOOR_W-1:0] floor);
        bus.req_valid = valid;
        bus.req_floor = floor;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic waitForState(input string tag, input logic [2:0] target, input int budget);
        int n = 0;
        while (bus.state !== target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(bus.state), 32'(target));
    endtask

    initial begin
        logic [2:0] expState;
        logic [2:0] expFloor;
        logic       expArrive;
        logic       expDoor;
        int         doorCount;
        int         guard;

        passCount  = 0;
        checkCount = 0;
        estop      = 1'b0;
        reset      = 1'b1;
        applyStimulus(1'b0, 3'd0);

        // Reset held for two cycles
        tick();
        tick();
        checkOutput("rst_cur_floor", 32'(bus.cur_floor), 32'd0);
        checkOutput("rst_state",     32'(bus.state),     32'(S_IDLE));
        checkOutput("rst_dir_up",    32'(bus.dir_up),    32'd1);
        checkOutput("rst_pending",   32'(bus.pending),   32'd0);
        checkOutput("rst_door_open", 32'(bus.door_open), 32'd0);
        checkOutput("rst_moving",    32'(bus.moving),    32'd0);
        checkOutput("rst_arrive",    32'(bus.arrive),    32'd0);

        // Single request to floor 3, cycle-exact timeline
        reset = 1'b0;
        applyStimulus(1'b1, 3'd3);
        tick();
        applyStimulus(1'b0, 3'd0);
        checkOutput("single_pending_c1", 32'(bus.pending), 32'b001000);
        checkOutput("single_state_c1",   32'(bus.state),   32'(S_IDLE));
        for (int c = 2; c <= 24; c++) begin
            tick();
            expArrive = (c == 7) || (c == 12) || (c == 17);
            expDoor   = (c >= 18) && (c <= 23);
            if (c == 2 || expArrive)  expState = S_DECIDE;
            else if (c <= 16)         expState = S_MOVE;
            else if (expDoor)         expState = S_DOOR;
            else                      expState = S_IDLE;
            if (c < 7)       expFloor = 3'd0;
            else if (c < 12) expFloor = 3'd1;
            else if (c < 17) expFloor = 3'd2;
            else             expFloor = 3'd3;
            checkOutput($sformatf("single_state_c%0d", c),  32'(bus.state),     32'(expState));
            checkOutput($sformatf("single_floor_c%0d", c),  32'(bus.cur_floor), 32'(expFloor));
            checkOutput($sformatf("single_arrive_c%0d", c), 32'(bus.arrive),    32'(expArrive));
            checkOutput($sformatf("single_door_c%0d", c),   32'(bus.door_open), 32'(expDoor));
        end
        checkOutput("single_pending_end", 32'(bus.pending), 32'd0);

        // SCAN order: at floor 2 heading up with 4 and 0 pending
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 3'd2);
        tick();
        applyStimulus(1'b0, 3'd0);
        waitForState("scan_door2", S_DOOR, 60);
        checkOutput("scan_floor2", 32'(bus.cur_floor), 32'd2);
        applyStimulus(1'b1, 3'd4);
        tick();
        applyStimulus(1'b1, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0);
        checkOutput("scan_pending", 32'(bus.pending), 32'b010001);
        waitForState("scan_decide2", S_DECIDE, 20);
        checkOutput("scan_decide2_floor", 32'(bus.cur_floor), 32'd2);
        checkOutput("scan_decide2_dir",   32'(bus.dir_up),    32'd1);
        waitForState("scan_door4", S_DOOR, 60);
        checkOutput("scan_floor4",   32'(bus.cur_floor), 32'd4);
        checkOutput("scan_dir_at4",  32'(bus.dir_up),    32'd1);
        waitForState("scan_move_down", S_MOVE, 20);
        checkOutput("scan_dir_down",    32'(bus.dir_up),    32'd0);
        checkOutput("scan_leave_floor", 32'(bus.cur_floor), 32'd4);
        waitForState("scan_door0", S_DOOR, 60);
        checkOutput("scan_floor0", 32'(bus.cur_floor), 32'd0);
        waitForState("scan_idle", S_IDLE, 20);
        checkOutput("scan_pending_end", 32'(bus.pending), 32'd0);

        // Door extend: same-floor request on the 4th door cycle
        applyStimulus(1'b1, 3'd0);
        tick();
        applyStimulus(1'b0, 3'd0);
        waitForState("extend_door", S_DOOR, 10);
        doorCount = 0;
        guard     = 0;
        while (bus.door_open === 1'b1 && guard < 40) begin
            doorCount++;
            applyStimulus(doorCount == 4, 3'd0);
            tick();
            guard++;
        end
        applyStimulus(1'b0, 3'd0);
        checkOutput("extend_door_cycles", 32'(doorCount),   32'd10);
        checkOutput("extend_pending",     32'(bus.pending), 32'd0);
        checkOutput("extend_idle",        32'(bus.state),   32'(S_IDLE));

        // Out-of-range request is ignored
        applyStimulus(1'b1, 3'd7);
        tick();
        applyStimulus(1'b0, 3'd0);
        checkOutput("oor_pending", 32'(bus.pending), 32'd0);
        checkOutput("oor_state",   32'(bus.state),   32'(S_IDLE));
        tick();
        checkOutput("oor_state2",  32'(bus.state),   32'(S_IDLE));

        // Reset mid-MOVE from floor 2 towards floor 5
        applyStimulus(1'b1, 3'd2);
        tick();
        applyStimulus(1'b0, 3'd0);
        waitForState("midrst_door2", S_DOOR, 60);
        waitForState("midrst_idle", S_IDLE, 20);
        applyStimulus(1'b1, 3'd5);
        tick();
        applyStimulus(1'b0, 3'd0);
        waitForState("midrst_move", S_MOVE, 10);
        tick();
        checkOutput("midrst_moving", 32'(bus.moving),    32'd1);
        checkOutput("midrst_floor",  32'(bus.cur_floor), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_cur_floor", 32'(bus.cur_floor), 32'd0);
        checkOutput("midrst_state",     32'(bus.state),     32'(S_IDLE));
        checkOutput("midrst_pending",   32'(bus.pending),   32'd0);
        checkOutput("midrst_moving0",   32'(bus.moving),    32'd0);
        checkOutput("midrst_dir_up",    32'(bus.dir_up),    32'd1);

`ifdef ELEVATOR_ESTOP_EN
        // Emergency stop for 5 cycles at MOVE timer=2
        applyStimulus(1'b1, 3'd1);
        tick();
        applyStimulus(1'b0, 3'd0);
        waitForState("estop_move", S_MOVE, 10);
        tick();
        tick();
        estop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("estop_halt_%0d", i),   32'(bus.state),  32'(S_HALT));
            checkOutput($sformatf("estop_moving_%0d", i), 32'(bus.moving), 32'd0);
        end
        estop = 1'b0;
        tick();
        checkOutput("estop_resume1_state", 32'(bus.state),     32'(S_MOVE));
        checkOutput("estop_resume1_floor", 32'(bus.cur_floor), 32'd0);
        tick();
        checkOutput("estop_resume2_state", 32'(bus.state),     32'(S_MOVE));
        checkOutput("estop_resume2_floor", 32'(bus.cur_floor), 32'd0);
        tick();
        checkOutput("estop_arrive_state",  32'(bus.state),     32'(S_DECIDE));
        checkOutput("estop_arrive_floor",  32'(bus.cur_floor), 32'd1);
        checkOutput("estop_arrive_pulse",  32'(bus.arrive),    32'd1);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
- Parametrised N-floor elevator controller; successor to the fixed single-request elevator FSM.
- Latches multiple floor requests into a pending bitmap and serves them in SCAN order: continue in the current direction while requests lie ahead, otherwise reverse.
- Uses internal travel and door timers instead of an external counter handshake.
- Sits between the request keypad/debounce logic and the floor display/motor drive outputs.

Parameters:
FLOORS, 8, number of floors (2..16); floors are numbered 0..FLOORS-1
FLOOR_W, 3, width of floor index; must satisfy 2^FLOOR_W >= FLOORS
TRAVEL_CYC, 16, cycles spent in MOVE per floor (>=1)
DOOR_CYC, 32, cycles the door stays open (>=1)
TMR_W, 8, timer width; must hold max(TRAVEL_CYC, DOOR_CYC)-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-high
req_valid  in  1  request strobe, sampled every cycle
req_floor  in  FLOOR_W  requested floor, qualified by req_valid
cur_floor  out  FLOOR_W  current floor (registered)
dir_up  out  1  1 = travelling/scanning up, 0 = down
moving  out  1  high while state==MOVE
door_open  out  1  high while state==DOOR
arrive  out  1  1-cycle pulse in the DECIDE cycle that follows a MOVE
pending  out  FLOORS  request bitmap
state  out  3  encoded state: IDLE=0, DECIDE=1, MOVE=2, DOOR=3, HALT=4

Behaviour:
- Reset values (reset sampled high at clk edge): state=IDLE, cur_floor=0, dir_up=1, pending=0, timer=0, moving=0, door_open=0, arrive=0.
- Reset has priority over all other inputs, including mid-MOVE and mid-DOOR; there is no resume after reset.
- Request latch, every non-reset cycle: if req_valid && req_floor<FLOORS, set pending[req_floor] at the next edge.
  - Exception: in DOOR with req_floor==cur_floor, the bit is not set; the door timer restarts at 0 instead.
  - req_floor>=FLOORS is silently ignored.
- When a new request sets a bit in the same cycle that bit is being cleared, set wins; the floor is served again later.
- IDLE: if pending!=0, go to DECIDE; otherwise stay.
- DECIDE (always exactly 1 cycle):
  - If pending[cur_floor]: clear it, go to DOOR.
  - Else if any pending bit lies ahead in dir_up (above cur_floor if up, below if down): go to MOVE.
  - Else if any pending bit lies behind: toggle dir_up, go to MOVE.
  - Else go to IDLE.
- MOVE:
  - Timer counts 0..TRAVEL_CYC-1.
  - On the edge leaving timer==TRAVEL_CYC-1: cur_floor +1 (up) or -1 (down), timer cleared, go to DECIDE.
  - MOVE therefore lasts exactly TRAVEL_CYC cycles.
  - cur_floor never leaves 0..FLOORS-1, because DECIDE only selects a direction that has a target.
- DOOR:
  - Timer counts 0..DOOR_CYC-1, then the state goes to DECIDE if pending!=0, else IDLE.
  - A same-floor request restarts the timer at 0, extending the door-open time.
- One floor costs TRAVEL_CYC+1 cycles (MOVE plus DECIDE).
- moving, door_open and arrive are registered and aligned with state.
- Default/illegal state encoding recovers to IDLE on the next edge.

Optional Feature:
- Macro: ELEVATOR_ESTOP_EN.
- When defined:
  - Adds input port estop (1 bit, level).
  - estop high, from any state except HALT: enter HALT at the next edge and save the state and timer; moving=0, door_open keeps its pre-halt value.
  - Requests are still latched while in HALT.
  - estop low: return to the saved state with the timer resumed from its saved value.
  - reset overrides HALT.
- When undefined: no estop port, no HALT state; encoding 4 is illegal and recovers to IDLE.

Test Plan:
All tests use FLOORS=6, FLOOR_W=3, TRAVEL_CYC=4, DOOR_CYC=6.
1. Reset: hold reset 2 cycles -> cur_floor=0, state=0, dir_up=1, pending=0, door_open=0, moving=0.
2. Single request: from IDLE at floor 0, req floor 3 at cycle 0 ->
   - pending=6'b001000 at cycle 1; DECIDE at cycle 2; MOVE cycles 3-6.
   - arrive pulses with cur_floor 1, 2, 3 at cycles 7, 12, 17.
   - door_open high cycles 18-23 exactly; pending=0; IDLE at cycle 24.
3. SCAN order: at floor 2 heading up with floors 4 and 0 pending -> stops at 4 first, then dir_up drops to 0 in the DECIDE after the door closes, then stops at 0.
4. Door extend: req cur_floor at door cycle 4 -> door_open lasts 4+6=10 cycles total; pending bit not set.
5. Out-of-range: req_floor=7 -> pending unchanged, state stays IDLE. Reset mid-MOVE (at floor 2 heading to 5) -> next cycle cur_floor=0, state=IDLE, pending=0.
6. ELEVATOR_ESTOP_EN: estop high 5 cycles at MOVE timer=2 -> state=4 and moving=0 for 5 cycles; after release MOVE resumes for 2 more cycles, then the floor increments.
